m_phy_lane_deser: RTL and testbench

- Parametrised serial-to-parallel lane deserializer with comma-based symbol alignment.
- Replaces the fixed 10-bit lane S2P.
- Adds configurable symbol width, multi-comma lock qualification, tolerant loss-of-lock, an alignment phase output and a realign counter.
- Sits between the lane CDR/sampler (one bit per clk) and the 8b10b decoder.

---
 rtl/m_phy_lane_deser.sv | 179 +++++++++++++++++
 tb/tb_m_phy_lane_deser.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_phy_lane_deser.sv
// m_phy_lane_deser: serial-to-parallel lane deserializer with comma alignment.
// Takes one serial bit per clk from the CDR/sampler. It hunts for comma_char in
// the shift window and qualifies lock over LOCK_CNT commas at one bit phase.
// Once locked it strobes aligned symbols out to the 8b10b decoder. LOSS_CNT
// misaligned commas seen since the last good comma drop lock.
// Optional: define M_PHY_DESER_DUAL_RD_EN to also accept ~comma_char, which is
// the other running-disparity form of the comma.
// Ports:
//   clk, reset      bit clock; synchronous active-high reset
//   serial_in       serial data; the first received bit becomes the symbol MSB
//   comma_char      comma pattern (quasi-static)
//   unlock          forces a re-hunt
//   parallel_out    aligned symbol, updated with data_valid
//   data_valid      one-cycle strobe per aligned symbol
//   is_comma        parallel_out is a comma (qualified by data_valid)
//   align_valid     lane is locked
//   align_phase     bit phase of the locked symbol boundary
//   realign_cnt     saturating count of exits from lock
module m_phy_lane_deser #(
    parameter int unsigned SYM_W    = 10,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serial_in,
    input  logic [SYM_W-1:0]         comma_char,
    input  logic                     unlock,
    output logic [SYM_W-1:0]         parallel_out,
    output logic                     data_valid,
    output logic                     is_comma,
    output logic                     align_valid,
    output logic [$clog2(SYM_W)-1:0] align_phase,
    output logic [7:0]               realign_cnt
);

    localparam int unsigned PH_W  = $clog2(SYM_W);
    localparam int unsigned CNT_W = 4;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SYM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HUNT,
        S_VERIFY,
        S_LOCK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SYM_W-1:0]  r_sr;
    logic [PH_W-1:0]   r_ph;
    logic [PH_W-1:0]   r_p;
    logic [PH_W-1:0]   w_p_nxt;
    logic [CNT_W-1:0]  r_hits;
    logic [CNT_W-1:0]  w_hits_nxt;
    logic [CNT_W-1:0]  w_hits_inc;
    logic [CNT_W-1:0]  r_miss;
    logic [CNT_W-1:0]  w_miss_nxt;
    logic [CNT_W-1:0]  w_miss_inc;
    logic              w_match;
    logic              w_on_phase;
    logic              w_strobe;
    logic              w_lock_exit;
    logic              w_lock_entry;

    // Comma compare on the registered window.
`ifdef M_PHY_DESER_DUAL_RD_EN
    assign w_match = (r_sr == comma_char) || (r_sr == ~comma_char);
`else
    assign w_match = (r_sr == comma_char);
`endif

    assign w_on_phase = (r_ph == r_p);
    assign w_hits_inc = r_hits + CNT_W'(1);
    assign w_miss_inc = r_miss + CNT_W'(1);
    // An unlock discards the symbol completing in the same cycle.
    assign w_strobe   = (r_state == S_LOCK) && w_on_phase && !unlock;
    assign w_lock_entry = (w_state_nxt == S_LOCK) && (r_state != S_LOCK);

    // Next-state logic for alignment hunt / verify / lock.
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_hits_nxt  = r_hits;
        w_miss_nxt  = r_miss;
        w_lock_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The phase counter starts at 0 on reset, so it doubles as the fill counter.
                if (r_ph == PH_LAST) begin
                    w_state_nxt = S_HUNT;
                end
            end
            S_HUNT: begin
                if (unlock) begin
                    w_hits_nxt = '0;
                end else if (w_match) begin
                    w_p_nxt     = r_ph;
                    w_hits_nxt  = CNT_W'(1);
                    w_state_nxt = (LOCK_CNT == 1) ? S_LOCK : S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (unlock) begin
                    w_state_nxt = S_HUNT;
                    w_hits_nxt  = '0;
                end else if (w_match && w_on_phase) begin
                    w_hits_nxt = w_hits_inc;
                    if (w_hits_inc >= CNT_W'(LOCK_CNT)) begin
                        w_state_nxt = S_LOCK;
                    end
                end else if (w_match) begin
                    // A comma at another phase restarts qualification from there.
                    w_p_nxt    = r_ph;
                    w_hits_nxt = CNT_W'(1);
                end
            end
            S_LOCK: begin
                if (unlock) begin
                    w_state_nxt = S_HUNT;
                    w_lock_exit = 1'b1;
                end else if (w_match && w_on_phase) begin
                    w_miss_nxt = '0;
                end else if (w_match) begin
                    w_miss_nxt = w_miss_inc;
                    if (w_miss_inc >= CNT_W'(LOSS_CNT)) begin
                        w_state_nxt = S_HUNT;
                        w_lock_exit = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_lock_entry) begin
            w_miss_nxt = '0;
            w_hits_nxt = '0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_ph         <= '0;
            r_p          <= '0;
            r_hits       <= '0;
            r_miss       <= '0;
            parallel_out <= '0;
            data_valid   <= 1'b0;
            is_comma     <= 1'b0;
            align_valid  <= 1'b0;
            align_phase  <= '0;
            realign_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= {r_sr[SYM_W-2:0], serial_in};
            r_ph        <= (r_ph == PH_LAST) ? '0 : r_ph + PH_W'(1);
            r_p         <= w_p_nxt;
            r_hits      <= w_hits_nxt;
            r_miss      <= w_miss_nxt;
            align_valid <= (w_state_nxt == S_LOCK);
            data_valid  <= w_strobe;
            if (w_strobe) begin
                parallel_out <= r_sr;
                is_comma     <= w_match;
            end
            if (w_lock_entry) begin
                align_phase <= w_p_nxt;
            end
            if (w_lock_exit && (realign_cnt != 8'hFF)) begin
                realign_cnt <= realign_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_phy_lane_deser.sv
// Testbench for m_phy_lane_deser (SYM_W=10, LOCK_CNT=2, LOSS_CNT=4).
// A behavioural model tracks the bit history and the cycle count since reset,
// and every output is compared each cycle. A table of stream segments carries
// the expected end-of-segment values. Hand sequences cover reset in lock, the
// dual-RD comma and realign_cnt saturation, followed by randomized traffic.
module tb_m_phy_lane_deser;

    localparam int SYM_W    = 10;
    localparam int LOCK_CNT = 2;
    localparam int LOSS_CNT = 4;
    localparam int PH_W     = $clog2(SYM_W);
    localparam logic [SYM_W-1:0] K_POS = 10'h0FA;
    localparam logic [SYM_W-1:0] K_NEG = 10'h305;

    localparam int MD_FILL    = 0;
    localparam int MD_SEARCH  = 1;
    localparam int MD_CONFIRM = 2;
    localparam int MD_LOCKED  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             serial_in;
    logic [SYM_W-1:0] comma_char;
    logic             unlock;
    logic [SYM_W-1:0] parallel_out;
    logic             data_valid;
    logic             is_comma;
    logic             align_valid;
    logic [PH_W-1:0]  align_phase;
    logic [7:0]       realign_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    m_phy_lane_deser #(
        .SYM_W    (SYM_W),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .comma_char   (comma_char),
        .unlock       (unlock),
        .parallel_out (parallel_out),
        .data_valid   (data_valid),
        .is_comma     (is_comma),
        .align_valid  (align_valid),
        .align_phase  (align_phase),
        .realign_cnt  (realign_cnt)
    );

    // Reference model state.
    int               m_mode;
    int               m_n;
    int               m_anchor;
    int               m_hits;
    int               m_miss;
    bit               m_hist[$];
    logic [SYM_W-1:0] e_pout;
    bit               e_dv;
    bit               e_isc;
    bit               e_av;
    int               e_aph;
    int               e_rc;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SYM_W-1:0] m_window();
        int v;
        v = 0;
        foreach (m_hist[i]) v = v * 2 + int'(m_hist[i]);
        return SYM_W'(v);
    endfunction

    task automatic model_reset();
        m_mode   = MD_FILL;
        m_n      = 0;
        m_anchor = 0;
        m_hits   = 0;
        m_miss   = 0;
        m_hist.delete();
        for (int i = 0; i < SYM_W; i++) m_hist.push_back(1'b0);
        e_pout = '0;
        e_dv   = 1'b0;
        e_isc  = 1'b0;
        e_av   = 1'b0;
        e_aph  = 0;
        e_rc   = 0;
    endtask

    // Applies one clock edge to the model using pre-edge inputs.
    task automatic model_step(input bit b, input bit u);
        int               ph;
        int               nxt;
        logic [SYM_W-1:0] win;
        bit               match;
        bit               aligned;
        bit               fire;
        ph    = m_n % SYM_W;
        win   = m_window();
        match = (win == comma_char);
`ifdef M_PHY_DESER_DUAL_RD_EN
        match = match || (win == ~comma_char);
`endif
        aligned = (ph == m_anchor);
        fire    = (m_mode == MD_LOCKED) && aligned && !u;
        nxt     = m_mode;
        case (m_mode)
            MD_FILL: if (m_n == SYM_W - 1) nxt = MD_SEARCH;
            MD_SEARCH: begin
                if (u) m_hits = 0;
                else if (match) begin
                    m_anchor = ph;
                    m_hits   = 1;
                    nxt      = (LOCK_CNT == 1) ? MD_LOCKED : MD_CONFIRM;
                end
            end
            MD_CONFIRM: begin
                if (u) begin
                    nxt    = MD_SEARCH;
                    m_hits = 0;
                end else if (match && aligned) begin
                    m_hits++;
                    if (m_hits >= LOCK_CNT) nxt = MD_LOCKED;
                end else if (match) begin
                    m_anchor = ph;
                    m_hits   = 1;
                end
            end
            default: begin
                if (u) begin
                    nxt  = MD_SEARCH;
                    e_rc = (e_rc < 255) ? e_rc + 1 : 255;
                end else if (match && aligned) begin
                    m_miss = 0;
                end else if (match) begin
                    m_miss++;
                    if (m_miss >= LOSS_CNT) begin
                        nxt  = MD_SEARCH;
                        e_rc = (e_rc < 255) ? e_rc + 1 : 255;
                    end
                end
            end
        endcase
        if (nxt == MD_LOCKED && m_mode != MD_LOCKED) begin
            e_aph  = m_anchor;
            m_miss = 0;
        end
        e_av = (nxt == MD_LOCKED);
        e_dv = fire;
        if (fire) begin
            e_pout = win;
            e_isc  = match;
        end
        m_mode = nxt;
        m_n++;
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic check_model();
        chk("model_pout", int'(parallel_out), int'(e_pout));
        chk("model_dv",   int'(data_valid),   int'(e_dv));
        chk("model_isc",  int'(is_comma),     int'(e_isc));
        chk("model_av",   int'(align_valid),  int'(e_av));
        chk("model_aph",  int'(align_phase),  e_aph);
        chk("model_rc",   int'(realign_cnt),  e_rc);
    endtask

    // One clock: drive inputs, let the edge happen, compare 1 time unit later.
    task automatic step(input bit b, input bit u, input bit rst);
        serial_in = b;
        unlock    = u;
        reset     = rst;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(b, u);
        #1;
        check_model();
    endtask

    typedef struct {
        int               pre_n;
        logic [SYM_W-1:0] pre_pat;
        int               commas;
        bit               unl;
        bit               av;
        int               aph;
        int               rc;
        bit               dv;
        logic [SYM_W-1:0] pout;
        bit               isc;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    initial begin
        bit               sb[$];
        int               chk_at[NV];
        int               r;
        bit               u;
        bit               b;
        logic [SYM_W-1:0] kc;
        logic [SYM_W-1:0] pat;
        logic [SYM_W-1:0] q_head;

        // Segments: pre-bits, commas, unlock on the decision cycle | expected after decision.
        tbl[0] = '{3, 10'h005, 2, 1'b0, 1'b1, 3, 0, 1'b0, 10'h000, 1'b0}; // lock at phase 3
        tbl[1] = '{0, 10'h000, 3, 1'b0, 1'b1, 3, 0, 1'b1, 10'h0FA, 1'b1}; // aligned comma strobe
        tbl[2] = '{1, 10'h000, 3, 1'b0, 1'b1, 3, 0, 1'b0, 10'h000, 1'b0}; // slip: 3 misses held
        tbl[3] = '{0, 10'h000, 1, 1'b0, 1'b0, 3, 1, 1'b0, 10'h000, 1'b0}; // 4th miss drops lock
        tbl[4] = '{0, 10'h000, 2, 1'b0, 1'b1, 4, 1, 1'b0, 10'h000, 1'b0}; // relock at phase 4
        tbl[5] = '{0, 10'h000, 1, 1'b1, 1'b0, 4, 2, 1'b0, 10'h000, 1'b0}; // unlock beats comma
        tbl[6] = '{9, 10'h000, 1, 1'b0, 1'b0, 4, 2, 1'b0, 10'h000, 1'b0}; // comma at phase 3
        tbl[7] = '{4, 10'h000, 1, 1'b0, 1'b0, 4, 2, 1'b0, 10'h000, 1'b0}; // restart at phase 7
        tbl[8] = '{0, 10'h000, 1, 1'b0, 1'b1, 7, 2, 1'b0, 10'h000, 1'b0}; // lock at phase 7
        tbl[9] = '{0, 10'h000, 1, 1'b0, 1'b1, 7, 2, 1'b1, 10'h0FA, 1'b1}; // strobe at phase 7

        reset      = 1'b1;
        serial_in  = 1'b0;
        unlock     = 1'b0;
        comma_char = K_POS;
        model_reset();

        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("reset_pout", int'(parallel_out), 0);
        chk("reset_dv",   int'(data_valid),   0);
        chk("reset_isc",  int'(is_comma),     0);
        chk("reset_av",   int'(align_valid),  0);
        chk("reset_aph",  int'(align_phase),  0);
        chk("reset_rc",   int'(realign_cnt),  0);

        // Build one continuous stream; each row is checked on the cycle after its last bit.
        kc = K_POS;
        for (int i = 0; i < NV; i++) begin
            pat = tbl[i].pre_pat;
            for (int j = tbl[i].pre_n - 1; j >= 0; j--) sb.push_back(pat[j]);
            for (int c = 0; c < tbl[i].commas; c++)
                for (int j = SYM_W - 1; j >= 0; j--) sb.push_back(kc[j]);
            chk_at[i] = sb.size();
        end
        sb.push_back(1'b0);

        r = 0;
        for (int i = 0; i < sb.size(); i++) begin
            u = 1'b0;
            if (r < NV && i == chk_at[r] && tbl[r].unl) u = 1'b1;
            step(sb[i], u, 1'b0);
            if (r < NV && i == chk_at[r]) begin
                chk($sformatf("row%0d_av", r),  int'(align_valid), int'(tbl[r].av));
                chk($sformatf("row%0d_aph", r), int'(align_phase), tbl[r].aph);
                chk($sformatf("row%0d_rc", r),  int'(realign_cnt), tbl[r].rc);
                chk($sformatf("row%0d_dv", r),  int'(data_valid),  int'(tbl[r].dv));
                if (tbl[r].dv) begin
                    chk($sformatf("row%0d_pout", r), int'(parallel_out), int'(tbl[r].pout));
                    chk($sformatf("row%0d_isc", r),  int'(is_comma),     int'(tbl[r].isc));
                end
                r++;
            end
        end

        // Reset while locked. The reset-zeroed window plus 11111010 forms a comma during the fill.
        step(1'b0, 1'b0, 1'b1);
        chk("midrst_av",  int'(align_valid), 0);
        chk("midrst_dv",  int'(data_valid),  0);
        chk("midrst_aph", int'(align_phase), 0);
        chk("midrst_rc",  int'(realign_cnt), 0);
        sb.delete();
        q_head = 10'h0FA;
        for (int j = 7; j >= 0; j--) sb.push_back(q_head[j]);
        for (int c = 0; c < 2; c++)
            for (int j = SYM_W - 1; j >= 0; j--) sb.push_back(kc[j]);
        sb.push_back(1'b0);
        for (int i = 0; i < sb.size(); i++) begin
            step(sb[i], 1'b0, 1'b0);
            if (i < SYM_W) begin
                chk("fill_av", int'(align_valid), 0);
                chk("fill_dv", int'(data_valid), 0);
            end
            if (i == 18) chk("fill_ignored_av", int'(align_valid), 0);
            if (i == 28) begin
                chk("relock_av",  int'(align_valid), 1);
                chk("relock_aph", int'(align_phase), 8);
                chk("relock_rc",  int'(realign_cnt), 0);
            end
        end

        // Second running-disparity form of the comma.
        step(1'b0, 1'b0, 1'b1);
`ifdef M_PHY_DESER_DUAL_RD_EN
        for (int c = 0; c <= 4 * SYM_W; c++) begin
            pat = ((c / SYM_W) % 2 == 0) ? K_POS : K_NEG;
            b = pat[SYM_W - 1 - (c % SYM_W)];
            step(b, 1'b0, 1'b0);
            if (c == 2 * SYM_W) chk("dual_av", int'(align_valid), 1);
            if (c == 3 * SYM_W) begin
                chk("dual_pos_dv",   int'(data_valid),   1);
                chk("dual_pos_pout", int'(parallel_out), int'(K_POS));
                chk("dual_pos_isc",  int'(is_comma),     1);
            end
            if (c == 4 * SYM_W) begin
                chk("dual_neg_dv",   int'(data_valid),   1);
                chk("dual_neg_pout", int'(parallel_out), int'(K_NEG));
                chk("dual_neg_isc",  int'(is_comma),     1);
            end
        end
`else
        pat = K_NEG;
        for (int c = 0; c <= 5 * SYM_W; c++) begin
            step(pat[SYM_W - 1 - (c % SYM_W)], 1'b0, 1'b0);
            chk("neg_only_av", int'(align_valid), 0);
        end
`endif

        // Lock / unlock cycles until realign_cnt saturates.
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c <= 30 * 262; c++) begin
            u = (c >= 30) && (c % 30 == 0);
            step(kc[SYM_W - 1 - (c % SYM_W)], u, 1'b0);
            if (c == 3000) begin
                chk("sat_rc_100", int'(realign_cnt), 100);
                chk("sat_unlock_nostrobe", int'(data_valid), 0);
            end
            if (c == 30 * 255) chk("sat_rc_255", int'(realign_cnt), 255);
        end
        chk("sat_rc_hold", int'(realign_cnt), 255);

        // Randomized traffic: junk, comma bursts, comma_char flips, rare unlock/reset.
        step(1'b0, 1'b0, 1'b1);
        for (int it = 0; it < 400; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) comma_char = (comma_char == K_POS) ? K_NEG : K_POS;
            if (sel < 4) begin
                int nb;
                nb = int'($urandom_range(1, 12));
                for (int j = 0; j < nb; j++)
                    step(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0),
                         ($urandom_range(0, 1999) == 0));
            end else begin
                int nc;
                nc = int'($urandom_range(1, 5));
                pat = comma_char;
                for (int c = 0; c < nc; c++)
                    for (int j = SYM_W - 1; j >= 0; j--)
                        step(pat[j], ($urandom_range(0, 199) == 0),
                             ($urandom_range(0, 1999) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
